// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default sizes and flattened-bus slicing helper for register_file_sb
package regfile_pkg;
    localparam int DW_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NREAD_DEF = 2;
    localparam int BUS_W = 256;
    function automatic logic [63:0] bus_slice(input logic [BUS_W-1:0] bus, input int idx, input int w);
        return 64'(bus >> (idx * w));
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write vector with claim-over-clear priority and per-port next-state lookup
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  claim_en,
    input  logic [AW-1:0]         claim_addr,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD-1:0]      rd_pend_d
);
    logic [DEPTH-1:0] pend_q, pend_d;
    // next pending vector: a new claim beats a retiring write; a hardwired zero register never waits
    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < DEPTH; r++)
            pend_d[r] = (claim_en && claim_addr == AW'(r)) ? 1'b1 :
                        (wr_en && wr_addr == AW'(r)) ? 1'b0 : pend_q[r];
        if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end
    // pending vector register
    always_ff @(posedge clk) pend_q <= reset ? '0 : pend_d;
    // each port sees the post-edge state so same-edge writes and claims are reflected
    always_comb begin
        rd_pend_d = '0;
        for (int i = 0; i < NREAD; i++)
            rd_pend_d[i] = pend_d[AW'(bus_slice(BUS_W'(rd_addr), i, AW))];
    end
endmodule

// File: rtl/register_file_sb.sv
// register_file_sb: multi-port register file with write-first bypass and pending-write scoreboard
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*DW-1:0]   rd_data,
    output logic [NREAD-1:0]      rd_pending,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  claim_en,
    input  logic [AW-1:0]         claim_addr
);
    logic [DW-1:0]       mem_q [DEPTH];
    logic [AW-1:0]       ra [NREAD];
    logic                wr_ok;
    logic [NREAD*DW-1:0] rd_data_d, rd_data_q;
    logic [NREAD-1:0]    rd_pend_d, rd_pend_q;

    assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == '0);

    // unpack the flattened read-address bus
    always_comb begin
        for (int i = 0; i < NREAD; i++)
            ra[i] = AW'(bus_slice(BUS_W'(rd_addr), i, AW));
    end
    // storage write port; reset clears every register
    always_ff @(posedge clk) begin
        if (reset)
            for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
        else if (wr_ok)
            mem_q[wr_addr] <= wr_data;
    end
    // read mux per port: hardwired zero, then write-first bypass, then storage
    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < NREAD; i++)
            rd_data_d[i*DW +: DW] = (ZERO_REG != 0 && ra[i] == '0) ? '0 :
                                    (wr_ok && wr_addr == ra[i]) ? wr_data : mem_q[ra[i]];
    end

    regfile_scoreboard #(
        .DEPTH(DEPTH), .NREAD(NREAD), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_sb (
        .clk(clk), .reset(reset), .claim_en(claim_en), .claim_addr(claim_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_pend_d(rd_pend_d)
    );

    // registered operand outputs
    always_ff @(posedge clk) begin
        rd_data_q <= reset ? '0 : rd_data_d;
        rd_pend_q <= reset ? '0 : rd_pend_d;
    end

    assign rd_data = rd_data_q;
    assign rd_pending = rd_pend_q;
endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb: randomized and directed checks of register_file_sb against a behavioural model
module tb_register_file_sb;
    logic        clk = 1'b0;
    logic        reset, wr_en, claim_en;
    logic [4:0]  wr_addr, claim_addr;
    logic [31:0] wr_data;
    logic [4:0]  ra_a [2];
    logic [4:0]  ra_b [3];
    logic [9:0]  a_rd_addr;
    logic [14:0] b_rd_addr;
    logic [63:0] a_rd_data;
    logic [47:0] b_rd_data;
    logic [1:0]  a_rd_pend;
    logic [2:0]  b_rd_pend;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    logic [31:0] mem [32];
    bit          pend [32];
    logic [31:0] exp_a_data [2];
    bit          exp_a_pend [2];
    logic [15:0] exp_b_data [3];
    bit          exp_b_pend [3];

    always #5 clk = ~clk;

    assign a_rd_addr = {ra_a[1], ra_a[0]};
    assign b_rd_addr = {ra_b[2], ra_b[1], ra_b[0]};

    register_file_sb dut_a (
        .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_pending(a_rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr)
    );

    register_file_sb #(.DW(16), .NREAD(3)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_pending(b_rd_pend),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[15:0]), .claim_en(claim_en), .claim_addr(claim_addr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // reference model: architectural state after each edge, reads taken from that state
    always @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                mem[r] = 0;
                pend[r] = 0;
            end
            for (int i = 0; i < 2; i++) begin
                exp_a_data[i] = 0;
                exp_a_pend[i] = 0;
            end
            for (int i = 0; i < 3; i++) begin
                exp_b_data[i] = 0;
                exp_b_pend[i] = 0;
            end
            started = 1;
        end else begin
            if (wr_en) pend[wr_addr] = 0;
            if (claim_en) pend[claim_addr] = 1;
            pend[0] = 0;
            if (wr_en && wr_addr != 0) mem[wr_addr] = wr_data;
            for (int i = 0; i < 2; i++) begin
                exp_a_data[i] = mem[ra_a[i]];
                exp_a_pend[i] = pend[ra_a[i]];
            end
            for (int i = 0; i < 3; i++) begin
                exp_b_data[i] = mem[ra_b[i]][15:0];
                exp_b_pend[i] = pend[ra_b[i]];
            end
        end
    end

    // compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("a_data%0d", i), 64'(a_rd_data[i*32 +: 32]), 64'(exp_a_data[i]));
                chk($sformatf("a_pend%0d", i), 64'(a_rd_pend[i]), 64'(exp_a_pend[i]));
            end
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b_data%0d", i), 64'(b_rd_data[i*16 +: 16]), 64'(exp_b_data[i]));
                chk($sformatf("b_pend%0d", i), 64'(b_rd_pend[i]), 64'(exp_b_pend[i]));
            end
        end
    end

    initial begin
        reset = 1; wr_en = 0; claim_en = 0; wr_addr = 0; claim_addr = 0; wr_data = 0;
        for (int i = 0; i < 2; i++) ra_a[i] = 0;
        for (int i = 0; i < 3; i++) ra_b[i] = 0;
        cyc(); cyc();
        reset = 0;
        for (int r = 0; r < 32; r++) begin
            ra_a[0] = 5'(r); ra_a[1] = 5'(r);
            cyc();
            chk("rst_data", 64'(a_rd_data), 64'h0);
            chk("rst_pend", 64'(a_rd_pend), 64'h0);
        end
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF; ra_a[0] = 5;
        cyc();
        chk("bypass", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
        wr_addr = 0; wr_data = 32'h1234; claim_en = 1; claim_addr = 0; ra_a[0] = 0;
        cyc();
        wr_en = 0; claim_en = 0;
        cyc();
        chk("zero_data", 64'(a_rd_data[31:0]), 64'h0);
        chk("zero_pend", 64'(a_rd_pend[0]), 64'h0);
        claim_en = 1; claim_addr = 7; ra_a[0] = 7;
        cyc();
        chk("claim_same", 64'(a_rd_pend[0]), 64'h1);
        claim_en = 0;
        cyc();
        chk("claim_next", 64'(a_rd_pend[0]), 64'h1);
        wr_en = 1; wr_addr = 7; wr_data = 32'h55;
        cyc();
        chk("clear_pend", 64'(a_rd_pend[0]), 64'h0);
        chk("clear_data", 64'(a_rd_data[31:0]), 64'h55);
        wr_data = 32'h66; claim_en = 1; claim_addr = 7;
        cyc();
        chk("both_pend", 64'(a_rd_pend[0]), 64'h1);
        chk("both_data", 64'(a_rd_data[31:0]), 64'h66);
        wr_en = 0; claim_en = 0;
        cyc();
        chk("both_hold", 64'(a_rd_pend[0]), 64'h1);
        wr_en = 1; wr_addr = 30; wr_data = 32'h12345678;
        cyc();
        wr_addr = 31; wr_data = 32'hA5A5A5A5;
        cyc();
        wr_en = 0; ra_b[0] = 31; ra_b[1] = 31; ra_b[2] = 30; ra_a[0] = 31; ra_a[1] = 30;
        cyc();
        chk("trunc0", 64'(b_rd_data[15:0]), 64'hA5A5);
        chk("trunc1", 64'(b_rd_data[31:16]), 64'hA5A5);
        chk("trunc2", 64'(b_rd_data[47:32]), 64'h5678);
        chk("wide31", 64'(a_rd_data), 64'h12345678_A5A5A5A5);
        claim_en = 1; claim_addr = 9; ra_a[0] = 9;
        cyc();
        chk("c9_pend", 64'(a_rd_pend[0]), 64'h1);
        reset = 1; wr_en = 1; wr_addr = 9; wr_data = 32'h77;
        cyc();
        chk("rst_win_data", 64'(a_rd_data), 64'h0);
        chk("rst_win_pend", 64'(a_rd_pend), 64'h0);
        reset = 0; wr_en = 0; claim_en = 0;
        cyc();
        chk("c9_after_pend", 64'(a_rd_pend[0]), 64'h0);
        chk("c9_after_data", 64'(a_rd_data[31:0]), 64'h0);
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            wr_en = 1'($urandom);
            claim_en = 1'($urandom);
            wr_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            claim_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wr_data = $urandom;
            for (int i = 0; i < 2; i++) ra_a[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) ra_b[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_sb.md
# register_file_sb

Parametrised, multi-read-port register file for the pipelined datapath, with a built-in pending-write scoreboard. It sits in the decode stage. It delivers registered operands one cycle after the address is presented and forwards same-cycle writeback data. For each operand it also flags whether a still-outstanding producer exists, so decode can stall. Register 0 is optionally hardwired to zero.

## Interface
Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; a power of two, at least 2.
- NREAD, 2, number of read ports, from 1 to 4.
- ZERO_REG, 1, when 1 register 0 reads zero, ignores writes and is never pending.
- AW, $clog2(DEPTH), address width; derived, never overridden.

Ports (the reset is synchronous and active-high):
- clk  in  1  single clock; every state element updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NREAD*DW  registered read data; port i occupies bits [i*DW +: DW].
- rd_pending  out  NREAD  registered; bit i set means the register read on port i had an outstanding claim.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  DW  writeback value.
- claim_en  in  1  issue strobe; marks claim_addr as awaiting a writeback.
- claim_addr  in  AW  destination register of the issuing instruction.

## Operation
- Storage is DEPTH×DW bits. A pending vector holds one bit per register.
- Reset clears all registers, all pending bits, rd_data and rd_pending to 0.
- Write: on a rising edge with wr_en=1, mem[wr_addr] takes wr_data. The write is dropped when ZERO_REG=1 and wr_addr=0.
- Read, for each port i on every edge:
  - rd_data[i] takes wr_data when wr_en=1, wr_addr=rd_addr[i] and the write is not dropped (write-first bypass).
  - Otherwise rd_data[i] takes mem[rd_addr[i]].
  - With ZERO_REG=1 and rd_addr[i]=0, rd_data[i] is always 0.
- Pending bit update per edge for register r:
  - The bit sets when claim_en=1 and claim_addr=r.
  - Otherwise it clears when wr_en=1 and wr_addr=r.
  - A claim and a write to the same register in the same edge leave the bit set: the newer producer wins.
  - Register 0 is never set when ZERO_REG=1.
- rd_pending[i] takes the next-state pending bit of rd_addr[i]:
  - A same-edge write clears the hazard.
  - A same-edge claim raises it.
- Multiple ports may read the same address; each gets identical data and flag.
- A write to a register with no claim is legal and does not touch the pending vector.
- A claim on a register that is already pending is legal; the bit stays set (single outstanding producer tracked).

## Timing
- Read latency is 1 cycle: the address is sampled at edge N and the data is valid after edge N until edge N+1.
- Write-to-read latency is 0 cycles through the bypass. It is 1 cycle through storage when the read address arrives later.
- There is no handshake and no backpressure. The block accepts one write, one claim and NREAD reads every cycle.
- When reset is asserted alongside other inputs, reset wins. Writes and claims on that edge are discarded, and outputs are 0 on the following cycle.
- Reset asserted mid-operation clears all pending claims. The pipeline must flush together with this block.

## Structure
- Package regfile_pkg holds:
  - the default constants DW_DEF=32, DEPTH_DEF=32 and NREAD_DEF=2;
  - the function to slice a flattened port bus.
- One sub-module, regfile_scoreboard, holds the pending vector, the claim/clear priority and the next-state lookup per read port.
- Storage, the bypass muxes and the output registers live in register_file_sb.
- No initial-file loading; contents are defined only by reset and writes.

## Test plan
- Reset, then read registers 0–31 on both ports: all rd_data=0 and rd_pending=0.
- Write 0xDEADBEEF to register 5, and on the same edge read register 5 on port 0. One cycle later rd_data[0]=0xDEADBEEF (bypass).
- Write 0x1234 to register 0 with ZERO_REG=1, then read register 0: rd_data=0 and rd_pending=0.
- Run three cases on register 7:
  - Claim, then read at the next edge: rd_pending=1.
  - Write 0x55: it clears, with rd_pending=0 on a same-edge read.
  - Claim and write on the same edge: the bit stays 1.
- Write 0xA5A5A5A5 to register 31, then read register 31 on both ports together with register 30 on a third port (NREAD=3, DW=16 variant): data is truncated correctly per port and port ordering is correct.
- Claim register 9 and assert reset on the next edge: rd_pending for register 9 is 0 after reset, and the register data is 0.
